// File: rtl/adder_pkg.sv
// ---------------------------------------------------------------------------
// adder_pkg
// Shared definitions for the ripple-carry full adder slice.
//   MAX_ADDER_WIDTH : widest legal operand width for full_adder.
//   majority3()     : carry function of a single full-adder cell.
//   ref_add()       : golden {carry, sum} of a + b + cin at the maximum
//                     width; narrower callers zero-extend their operands and
//                     keep the low WIDTH+1 bits of the result.
// ---------------------------------------------------------------------------
package adder_pkg;

    localparam int MAX_ADDER_WIDTH = 64;

    // Carry-out of one cell: set when at least two of the three inputs are set.
    function automatic logic majority3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    // Exact (MAX_ADDER_WIDTH+1)-bit result of a + b + cin, no truncation.
    function automatic logic [MAX_ADDER_WIDTH:0] ref_add(
        input logic [MAX_ADDER_WIDTH-1:0] a,
        input logic [MAX_ADDER_WIDTH-1:0] b,
        input logic                       cin
    );
        return {1'b0, a} + {1'b0, b} + {{MAX_ADDER_WIDTH{1'b0}}, cin};
    endfunction

endpackage : adder_pkg

// File: rtl/fa_cell.sv
// ---------------------------------------------------------------------------
// fa_cell
// Purely combinational one-bit full adder, the leaf of the carry chain.
//   a, b  : addend bits
//   cin   : carry from the next lower cell (or the block carry-in)
//   s     : sum bit, a ^ b ^ cin
//   cout  : carry to the next higher cell, majority(a, b, cin)
// ---------------------------------------------------------------------------
module fa_cell
    import adder_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = majority3(a, b, cin);

endmodule : fa_cell

// File: rtl/full_adder.sv
// ---------------------------------------------------------------------------
// full_adder
// Registered WIDTH-bit ripple-carry adder: {Cout, Sum} = A + B + Cin with
// exactly one cycle of latency and a valid qualifier.
//   clk       : rising-edge clock
//   reset     : asynchronous, active-high; clears Sum, Cout and out_valid
//   in_valid  : A/B/Cin are valid this cycle
//   A, B      : unsigned addends, WIDTH bits (legal WIDTH is 1..64)
//   Cin       : carry into bit 0
//   Sum       : registered sum
//   Cout      : registered carry out of the MSB cell
//   out_valid : Sum/Cout were produced from a valid input on the last edge
// When in_valid is low at an edge, Sum/Cout hold and out_valid drops.
// ---------------------------------------------------------------------------
module full_adder #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             out_valid
);

    // carry_s[i] is the carry into cell i; carry_s[WIDTH] leaves the MSB.
    logic [WIDTH:0]   carry_s;
    logic [WIDTH-1:0] sum_s;

    logic [WIDTH-1:0] sum_d,   sum_q;
    logic             cout_d,  cout_q;
    logic             valid_d, valid_q;

    assign carry_s[0] = Cin;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_cell
            fa_cell u_cell (
                .a    (A[gi]),
                .b    (B[gi]),
                .cin  (carry_s[gi]),
                .s    (sum_s[gi]),
                .cout (carry_s[gi+1])
            );
        end
    endgenerate

    // Next-state: load the chain result on a valid input, otherwise hold.
    always_comb begin
        sum_d   = sum_q;
        cout_d  = cout_q;
        valid_d = in_valid;
        if (in_valid) begin
            sum_d  = sum_s;
            cout_d = carry_s[WIDTH];
        end else begin
            sum_d  = sum_q;
            cout_d = cout_q;
        end
    end

    // Output registers; reset discards any in-flight result immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_q   <= {WIDTH{1'b0}};
            cout_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            valid_q <= valid_d;
        end
    end

    assign Sum       = sum_q;
    assign Cout      = cout_q;
    assign out_valid = valid_q;

endmodule : full_adder

// File: tb/tb_full_adder.sv
// ---------------------------------------------------------------------------
// tb_full_adder
// Drives a 1-bit and an 8-bit full_adder side by side. Expected results come
// from plain integer arithmetic on the applied operands plus a one-entry
// "last result" model that captures the hold and valid rules.
// ---------------------------------------------------------------------------
module tb_full_adder;

    logic       clk = 1'b0;
    always #10 clk = ~clk;

    // 1-bit instance
    logic       rst1, v1, a1, b1, c1;
    logic       s1, co1, ov1;

    // 8-bit instance
    logic       rst8, v8, c8;
    logic [7:0] a8, b8;
    logic [7:0] s8;
    logic       co8, ov8;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    // Reference state for the 8-bit instance.
    int   exp_res8 = 0;
    logic exp_v8   = 1'b0;

    full_adder #(.WIDTH(1)) dut1 (
        .clk       (clk),
        .reset     (rst1),
        .in_valid  (v1),
        .A         (a1),
        .B         (b1),
        .Cin       (c1),
        .Sum       (s1),
        .Cout      (co1),
        .out_valid (ov1)
    );

    full_adder #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .reset     (rst8),
        .in_valid  (v8),
        .A         (a8),
        .B         (b8),
        .Cin       (c8),
        .Sum       (s8),
        .Cout      (co8),
        .out_valid (ov8)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle on the 8-bit instance: apply at negedge, update the model at
    // the capturing edge, compare shortly after it.
    task automatic step8(input logic [7:0] a, input logic [7:0] b, input logic c,
                         input logic v, input string tag);
        @(negedge clk);
        a8 = a; b8 = b; c8 = c; v8 = v;
        @(posedge clk);
        if (v) exp_res8 = int'(a) + int'(b) + int'(c);
        exp_v8 = v;
        #1;
        check({tag, "_sum"},   64'(s8),  64'(exp_res8 % 256));
        check({tag, "_cout"},  64'(co8), 64'(exp_res8 / 256));
        check({tag, "_valid"}, 64'(ov8), 64'(exp_v8));
    endtask

    initial begin
        logic [2:0] vec;
        int         exp1;

        rst1 = 1'b1; v1 = 1'b0; a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
        rst8 = 1'b1; v8 = 1'b0; a8 = 8'h00; b8 = 8'h00; c8 = 1'b0;

        // Reset state, before any clock edge
        #5;
        check("rst1_state", 64'({co1, s1, ov1}), 64'd0);
        check("rst8_state", 64'({co8, s8, ov8}), 64'd0);
        @(posedge clk);
        #5;
        rst1 = 1'b0;
        rst8 = 1'b0;

        // WIDTH=1 exhaustive over {B,A,Cin}
        for (int v = 0; v < 8; v++) begin
            vec = v[2:0];
            @(negedge clk);
            {b1, a1, c1} = vec;
            v1 = 1'b1;
            @(posedge clk);
            #1;
            exp1 = int'(vec[2]) + int'(vec[1]) + int'(vec[0]);
            check($sformatf("exh%0d_cs", v), 64'({co1, s1}), 64'(exp1));
            check($sformatf("exh%0d_valid", v), 64'(ov1), 64'd1);
        end

        // Reset asserted between edges while Sum=1, out_valid=1
        @(negedge clk);
        a1 = 1'b1; b1 = 1'b0; c1 = 1'b0; v1 = 1'b1;
        @(posedge clk);
        #1;
        check("pre_rst_sum", 64'({co1, s1, ov1}), 64'b011);
        #4;
        rst1 = 1'b1;
        #1;
        check("async_rst_clear", 64'({co1, s1, ov1}), 64'd0);
        @(posedge clk);
        #1;
        check("rst_held_edge", 64'({co1, s1, ov1}), 64'd0);
        #3;
        rst1 = 1'b0;
        #1;
        check("post_deassert", 64'({co1, s1, ov1}), 64'd0);
        @(posedge clk);
        #1;
        check("first_after_rst", 64'({co1, s1, ov1}), 64'b011);

        // Hold: valid 1+1+0, then invalid zeros
        @(negedge clk);
        a1 = 1'b1; b1 = 1'b1; c1 = 1'b0; v1 = 1'b1;
        @(posedge clk);
        #1;
        check("hold_load", 64'({co1, s1, ov1}), 64'b101);
        @(negedge clk);
        a1 = 1'b0; b1 = 1'b0; c1 = 1'b0; v1 = 1'b0;
        @(posedge clk);
        #1;
        check("hold_keep1", 64'({co1, s1, ov1}), 64'b100);
        @(posedge clk);
        #1;
        check("hold_keep2", 64'({co1, s1, ov1}), 64'b100);

        // WIDTH=8 boundaries
        step8(8'hFF, 8'h00, 1'b1, 1'b1, "ripple");
        check("ripple_const", 64'({co8, s8}), 64'h100);
        step8(8'hFF, 8'hFF, 1'b1, 1'b1, "max");
        check("max_const", 64'({co8, s8}), 64'h1FF);
        step8(8'h00, 8'h00, 1'b0, 1'b1, "zero");
        check("zero_const", 64'({co8, s8}), 64'h000);
        step8(8'h5A, 8'hA5, 1'b0, 1'b0, "idle8");

        // WIDTH=8 back-to-back random valid stream
        for (int i = 0; i < 1000; i++) begin
            step8(8'($urandom_range(255)), 8'($urandom_range(255)),
                  1'($urandom_range(1)), 1'b1, "b2b");
        end

        // Random stream with gaps and a reset pulse in the middle
        for (int i = 0; i < 300; i++) begin
            step8(8'($urandom_range(255)), 8'($urandom_range(255)),
                  1'($urandom_range(1)), ($urandom_range(3) != 0), "mix");
            if (i == 150) begin
                #3;
                rst8 = 1'b1;
                #1;
                check("mid_rst_clear", 64'({co8, s8, ov8}), 64'd0);
                exp_res8 = 0;
                exp_v8   = 1'b0;
                @(posedge clk);
                #1;
                check("mid_rst_edge", 64'({co8, s8, ov8}), 64'd0);
                #2;
                rst8 = 1'b0;
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_full_adder

// File: doc/full_adder.md
Name: full_adder

Overview:
- Registered full adder. Computes Sum = A xor B xor Cin and Cout = majority(A, B, Cin), bit-sliced over WIDTH bits as a ripple-carry chain.
- Used as the arithmetic leaf cell in datapath blocks. The default WIDTH=1 is the classic one-bit full adder.
- Outputs are registered, with a simple valid qualifier, so it drops directly into pipelined datapaths.

Parameters:
- WIDTH, 1, operand width in bits (legal range 1..64). Each bit is one full-adder cell and carry ripples LSB to MSB.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands A/B/Cin are valid this cycle.
- A  input  WIDTH  addend A, unsigned.
- B  input  WIDTH  addend B, unsigned.
- Cin  input  1  carry-in into bit 0.
- Sum  output  WIDTH  registered sum bits.
- Cout  output  1  registered carry-out of the MSB cell.
- out_valid  output  1  Sum/Cout hold a result computed from a valid input.

Behaviour:
- Reset:
  - While reset=1, Sum=0, Cout=0 and out_valid=0, immediately and independent of clk.
  - After reset deasserts, operation starts at the first rising clk edge.
- Arithmetic:
  - {Cout, Sum} = A + B + Cin, computed exactly in WIDTH+1 bits with no truncation.
  - Per bit i: s[i] = A[i]^B[i]^c[i]; c[i+1] = (A[i]&B[i]) | (A[i]&Cin_i) | (B[i]&c[i]), where c[0]=Cin and Cout=c[WIDTH].
- Latency:
  - Exactly one cycle. The result of the operands sampled at edge N is visible on Sum/Cout after edge N.
  - out_valid is a registered copy of in_valid with the same one-cycle delay.
- Hold:
  - When in_valid=0 at an edge, Sum and Cout keep their previous values and out_valid goes to 0.
  - Back-to-back valid inputs produce back-to-back results. There is no backpressure and no stall input.
- Boundary cases:
  - Maximum case A=B=all-ones, Cin=1 gives Sum=all-ones, Cout=1.
  - All-zero inputs give Sum=0, Cout=0.
  - Carry propagates the full chain when A=all-ones, B=0, Cin=1, giving Sum=0, Cout=1.
- Reset mid-operation:
  - Asserting reset at any time clears the outputs and out_valid asynchronously. Any in-flight result is discarded.
  - An edge coincident with reset deassertion does not capture data.
- No X propagation on the outputs after reset, regardless of input history.
- Fully synchronous datapath otherwise. The combinational carry chain is contained between the input sampling point and the output register.

Decomposition:
- Shared package adder_pkg: constant MAX_ADDER_WIDTH=64, plus a function ref_add(a, b, cin) returning a WIDTH+1-bit golden value for benches.
- One sub-module, fa_cell: purely combinational one-bit full adder with ports a, b, cin, s, cout.
- full_adder generates WIDTH instances of fa_cell chained on carry, then registers {Cout, Sum, out_valid}.

Test Plan:
- WIDTH=1 exhaustive: drive {B,A,Cin} = 0..7 with in_valid=1, one vector per 20 ns step. Next-cycle {Cout,Sum} must be:
  - 0→00, 1→01, 2→01, 3→10, 4→01, 5→10, 6→10, 7→11.
- Reset behaviour: assert reset between clock edges while out_valid=1 and Sum=1. Sum, Cout and out_valid must read 0 before the next edge, and stay 0 until the first edge after deassertion.
- Hold: apply A=1,B=1,Cin=0 valid, then in_valid=0 with A=0,B=0,Cin=0. Sum=0/Cout=1 must persist and out_valid must fall to 0.
- WIDTH=8 carry ripple: A=8'hFF, B=8'h00, Cin=1 → Sum=8'h00, Cout=1. Then A=8'hFF, B=8'hFF, Cin=1 → Sum=8'hFF, Cout=1.
- WIDTH=8 back-to-back random: 1000 valid vectors, one per cycle. Each output must equal ref_add of the previous cycle's inputs, and out_valid must track in_valid delayed by 1.
- Reset mid-stream: reset pulse during a random valid stream. Outputs clear immediately, and the first post-reset result corresponds to the first valid input sampled after deassertion.
